// File: rtl/sdram_phase_sweep.sv
`default_nettype none
// ============================================================================
// sdram_phase_sweep : sweeps SDRAM clock phase, scores each step, centres on
// the longest error-free run. Optional BCD phase readout: PHASE_SWEEP_BCD_EN.
// Revision: 1.0
// ============================================================================
module sdram_phase_sweep #(
  parameter int N_STEPS    = 64,
  parameter int SETTLE_CYC = 1024,
  parameter int WINDOW_CYC = 1048576,
  parameter int STEP_HI    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step_up,
  input  logic        step_dn,
  input  logic [31:0] passcount,
  input  logic [31:0] failcount,
  output logic        phasedir,
  output logic        phasestep,
  output logic [7:0]  phase,
  output logic        busy,
  output logic        done,
  output logic        no_window,
  output logic [7:0]  win_lo,
  output logic [7:0]  win_len,
  output logic [11:0] phase_bcd
);

  localparam logic [31:0] C_SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] C_WINDOW_LAST = 32'(WINDOW_CYC - 1);
  localparam logic [31:0] C_HI_LAST     = 32'(STEP_HI - 1);
  localparam logic [7:0]  C_K_LAST      = 8'(N_STEPS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DIR     = 4'd1,
    S_PULSE   = 4'd2,
    S_SETTLE  = 4'd3,
    S_SNAP    = 4'd4,
    S_MEASURE = 4'd5,
    S_EVAL    = 4'd6,
    S_CENTER  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [7:0]  k;
  logic [31:0] snap_p;
  logic [31:0] snap_f;
  logic [7:0]  cur_len;
  logic [7:0]  cur_lo;
  logic [7:0]  start_phase;
  logic        centering;

  logic [31:0] diff_p;
  logic [31:0] diff_f;
  logic        good;
  logic [7:0]  run_len_next;
  logic [7:0]  run_lo_next;
  logic [7:0]  center_target;

  // Modular subtraction keeps the score correct across counter wrap.
  assign diff_p        = passcount - snap_p;
  assign diff_f        = failcount - snap_f;
  assign good          = (diff_f == 32'd0) && (diff_p != 32'd0);
  assign run_len_next  = cur_len + 8'd1;
  assign run_lo_next   = (cur_len == 8'd0) ? phase : cur_lo;
  assign center_target = (win_len == 8'd0) ? start_phase
                                           : win_lo + {1'b0, win_len[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 32'd0;
      k           <= 8'd0;
      snap_p      <= 32'd0;
      snap_f      <= 32'd0;
      cur_len     <= 8'd0;
      cur_lo      <= 8'd0;
      start_phase <= 8'd0;
      centering   <= 1'b0;
      phasedir    <= 1'b0;
      phasestep   <= 1'b0;
      phase       <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      no_window   <= 1'b0;
      win_lo      <= 8'd0;
      win_len     <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy        <= 1'b1;
            done        <= 1'b0;
            no_window   <= 1'b0;
            win_lo      <= 8'd0;
            win_len     <= 8'd0;
            cur_len     <= 8'd0;
            cur_lo      <= 8'd0;
            k           <= 8'd0;
            centering   <= 1'b0;
            start_phase <= phase;
            phasedir    <= 1'b1;
            state       <= S_DIR;
          end else if (step_up ^ step_dn) begin
            phasedir <= step_up;
            state    <= S_DIR;
          end
        end
        S_DIR: begin
          phasestep <= 1'b1;
          phase     <= phasedir ? phase + 8'd1 : phase - 8'd1;
          cnt       <= 32'd0;
          state     <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt == C_HI_LAST) begin
            phasestep <= 1'b0;
            cnt       <= 32'd0;
            // Manual steps return to whichever resting state issued them.
            if (!busy)          state <= done ? S_DONE : S_IDLE;
            else if (centering) state <= S_CENTER;
            else                state <= S_SETTLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          if (cnt == C_SETTLE_LAST) begin
            cnt   <= 32'd0;
            state <= S_SNAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SNAP: begin
          snap_p <= passcount;
          snap_f <= failcount;
          cnt    <= 32'd0;
          state  <= S_MEASURE;
        end
        S_MEASURE: begin
          if (cnt == C_WINDOW_LAST) begin
            cnt   <= 32'd0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_EVAL: begin
          if (good) begin
            cur_len <= run_len_next;
            cur_lo  <= run_lo_next;
            // Strictly longer only, so an equal later run never displaces the earlier one.
            if (run_len_next > win_len) begin
              win_len <= run_len_next;
              win_lo  <= run_lo_next;
            end
          end else begin
            cur_len <= 8'd0;
          end
          if (k == C_K_LAST) begin
            centering <= 1'b1;
            state     <= S_CENTER;
          end else begin
            k        <= k + 8'd1;
            phasedir <= 1'b1;
            state    <= S_DIR;
          end
        end
        S_CENTER: begin
          if (phase == center_target) begin
            no_window <= (win_len == 8'd0);
            busy      <= 1'b0;
            done      <= 1'b1;
            centering <= 1'b0;
            state     <= S_DONE;
          end else begin
            phasedir <= 1'b0;
            state    <= S_DIR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PHASE_SWEEP_BCD_EN
  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    return sh[19:8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_bcd <= 12'h000;
    else        phase_bcd <= to_bcd(phase);
  end
`else
  assign phase_bcd = 12'h000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_phase_sweep.sv
`default_nettype none
// Directed bench for sdram_phase_sweep: PLL and mem_tester modelled from phasestep/phasedir.
module tb_sdram_phase_sweep;

  localparam int N_STEPS    = 16;
  localparam int SETTLE_CYC = 4;
  localparam int WINDOW_CYC = 16;
  localparam int STEP_HI    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step_up = 1'b0;
  logic        step_dn = 1'b0;
  logic [31:0] passcount = 32'hFFFF_FFF0;
  logic [31:0] failcount = 32'hFFFF_FFF8;
  logic        phasedir;
  logic        phasestep;
  logic [7:0]  phase;
  logic        busy;
  logic        done;
  logic        no_window;
  logic [7:0]  win_lo;
  logic [7:0]  win_len;
  logic [11:0] phase_bcd;

  int          checks = 0;
  int          errors = 0;
  int          rises = 0;
  int          hi = 0;
  logic        ps_q = 1'b0;
  logic        pd_q = 1'b0;
  logic [7:0]  pll_phase = 8'd0;
  logic [255:0] good_mask = '0;

  sdram_phase_sweep #(
    .N_STEPS(N_STEPS), .SETTLE_CYC(SETTLE_CYC),
    .WINDOW_CYC(WINDOW_CYC), .STEP_HI(STEP_HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_up(step_up), .step_dn(step_dn),
    .passcount(passcount), .failcount(failcount), .phasedir(phasedir),
    .phasestep(phasestep), .phase(phase), .busy(busy), .done(done),
    .no_window(no_window), .win_lo(win_lo), .win_len(win_len), .phase_bcd(phase_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PLL + memory tester model: phase follows strobes; failures depend on the modelled phase.
  always @(negedge clk) begin
    if (!rst_n) begin
      ps_q = 1'b0; pd_q = 1'b0; hi = 0; pll_phase = 8'd0;
    end else begin
      if (phasestep && !ps_q) begin
        rises++;
        check("dir_setup", {31'd0, phasedir}, {31'd0, pd_q});
        pll_phase = phasedir ? pll_phase + 8'd1 : pll_phase - 8'd1;
      end
      if (phasestep) begin
        if (ps_q) check("dir_hold", {31'd0, phasedir}, {31'd0, pd_q});
        hi++;
      end
      if (!phasestep && ps_q) begin
        check("pulse_width", hi, STEP_HI);
        hi = 0;
      end
      ps_q = phasestep;
      pd_q = phasedir;
    end
    passcount = passcount + 32'd1;
    if (!good_mask[pll_phase]) failcount = failcount + 32'd1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    rises = 0;
  endtask

  task automatic pulse(input logic s, input logic u, input logic d);
    @(posedge clk); #1;
    start = s; step_up = u; step_dn = d;
    @(posedge clk); #1;
    start = 1'b0; step_up = 1'b0; step_dn = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
    idle(2);
  endtask

  initial begin
    // Reset state, idle with no stimulus
    do_reset();
    idle(20);
    check("rst_phase", phase, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nowin", no_window, 0);
    check("rst_winlo", win_lo, 0);
    check("rst_winlen", win_len, 0);
    check("rst_bcd", phase_bcd, 0);
    check("rst_dir", phasedir, 0);
    check("rst_rises", rises, 0);

    // Manual steps: up x3, down x1
    pulse(0, 1, 0); idle(10);
    pulse(0, 1, 0); idle(10);
    pulse(0, 1, 0); idle(10);
    pulse(0, 0, 1); idle(10);
    check("man_rises", rises, 4);
    check("man_phase", phase, 2);
    check("man_pll", pll_phase, 2);
    // Second request while the first step is running is dropped; up&dn together ignored
    pulse(0, 1, 0); pulse(0, 1, 0); idle(10);
    pulse(0, 1, 1); idle(10);
    check("drop_rises", rises, 5);
    check("drop_phase", phase, 3);

    // Reset mid-step forces phasestep low at once
    pulse(0, 1, 0);
    @(posedge clk); #1;
    check("mid_step_hi", phasestep, 1);
    rst_n = 1'b0; #1;
    check("rst_async_step", phasestep, 0);
    check("rst_async_phase", phase, 0);
    do_reset();

    // Sweep: good k=5..10 => phases 6..11
    good_mask = '0;
    for (int p = 6; p <= 11; p++) good_mask[p] = 1'b1;
    pulse(1, 0, 0);
    check("busy_after_start", busy, 1);
    wait_done(5000);
    check("s1_winlo", win_lo, 6);
    check("s1_winlen", win_len, 6);
    check("s1_phase", phase, 9);
    check("s1_pll", pll_phase, 9);
    check("s1_busy", busy, 0);
    check("s1_nowin", no_window, 0);
    check("s1_rises", rises, 23);

    // Sweep from phase 9 with every step failing
    good_mask = '0;
    rises = 0;
    pulse(1, 0, 0);
    wait_done(5000);
    check("s2_nowin", no_window, 1);
    check("s2_winlen", win_len, 0);
    check("s2_phase", phase, 9);
    check("s2_pll", pll_phase, 9);
    check("s2_rises", rises, 32);

    // Two equal runs k=1..3 and k=8..10; manual and start pulses during busy ignored
    do_reset();
    good_mask = '0;
    for (int p = 2; p <= 4; p++) good_mask[p] = 1'b1;
    for (int p = 9; p <= 11; p++) good_mask[p] = 1'b1;
    pulse(1, 0, 0);
    idle(5);
    pulse(0, 1, 0); idle(40);
    pulse(0, 0, 1); idle(40);
    pulse(1, 0, 0);
    wait_done(5000);
    check("s3_winlo", win_lo, 2);
    check("s3_winlen", win_len, 3);
    check("s3_phase", phase, 3);
    check("s3_rises", rises, 29);
    check("s3_done", done, 1);

    // Wrap below zero and BCD readout
    do_reset();
    pulse(0, 0, 1); idle(10);
    check("wrap_phase", phase, 255);
`ifdef PHASE_SWEEP_BCD_EN
    check("bcd_255", phase_bcd, 32'h255);
`else
    check("bcd_off", phase_bcd, 32'h000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
